// File: rtl/cpu_pkg.sv
// Shared pipeline types: widths, ALU opcodes and the control bundle
// carried from decode into execute.
package cpu_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 16;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] alu_op;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and the flush / busy / hazard priority
// that decides whether ID/EX captures, holds or takes a bubble.
module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic             idex_valid,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_dst,
    input  logic             ifid_valid,
    input  logic [REG_W-1:0] ifid_op1,
    input  logic [REG_W-1:0] ifid_op2,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             hazard,
    output logic             stall,
    output logic             bubble
);

    logic src_match;

    assign src_match = (idex_dst == ifid_op1) | (idex_dst == ifid_op2);

    assign hazard = idex_valid & idex_mem_read & (idex_dst != '0)
                  & ifid_valid & src_match;

    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        if (flush) begin
            bubble = 1'b1;
        end else if (mem_busy) begin
            stall  = 1'b1;
        end else if (hazard) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall insertion and a
// saturating count of stalled cycles.
module idex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifid_valid,
    input  logic [REG_W-1:0]  ifid_op1,
    input  logic [REG_W-1:0]  ifid_op2,
    input  logic [REG_W-1:0]  ifid_dst,
    input  logic [DATA_W-1:0] ifid_rdata1,
    input  logic [DATA_W-1:0] ifid_rdata2,
    input  logic [DATA_W-1:0] ifid_imm,
    input  logic              ifid_reg_write,
    input  logic              ifid_mem_read,
    input  logic              ifid_mem_write,
    input  logic [3:0]        ifid_alu_op,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              idex_valid,
    output logic [REG_W-1:0]  idex_op1,
    output logic [REG_W-1:0]  idex_op2,
    output logic [REG_W-1:0]  idex_dst,
    output logic [DATA_W-1:0] idex_rdata1,
    output logic [DATA_W-1:0] idex_rdata2,
    output logic [DATA_W-1:0] idex_imm,
    output logic              idex_reg_write,
    output logic              idex_mem_read,
    output logic              idex_mem_write,
    output logic [3:0]        idex_alu_op,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    logic              valid_q, valid_d;
    logic [REG_W-1:0]  op1_q, op1_d;
    logic [REG_W-1:0]  op2_q, op2_d;
    logic [REG_W-1:0]  dst_q, dst_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;
    ctrl_t             ifid_ctrl;

    assign ifid_ctrl = '{reg_write: ifid_reg_write,
                         mem_read:  ifid_mem_read,
                         mem_write: ifid_mem_write,
                         alu_op:    ifid_alu_op};

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_valid    (valid_q),
        .idex_mem_read (ctrl_q.mem_read),
        .idex_dst      (dst_q),
        .ifid_valid    (ifid_valid),
        .ifid_op1      (ifid_op1),
        .ifid_op2      (ifid_op2),
        .flush         (flush),
        .mem_busy      (mem_busy),
        .hazard        (hazard),
        .stall         (stall),
        .bubble        (bubble)
    );

    // A bubble is all-zero so forwarding never matches on it.
    always_comb begin
        valid_d  = valid_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        dst_d    = dst_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        if (bubble || (!stall && !ifid_valid)) begin
            valid_d  = 1'b0;
            op1_d    = '0;
            op2_d    = '0;
            dst_d    = '0;
            rdata1_d = '0;
            rdata2_d = '0;
            imm_d    = '0;
            ctrl_d   = BUBBLE_CTRL;
        end else if (!stall) begin
            valid_d  = 1'b1;
            op1_d    = ifid_op1;
            op2_d    = ifid_op2;
            dst_d    = ifid_dst;
            rdata1_d = ifid_rdata1;
            rdata2_d = ifid_rdata2;
            imm_d    = ifid_imm;
            ctrl_d   = ifid_ctrl;
        end
    end

    assign cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            dst_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= BUBBLE_CTRL;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            dst_q    <= dst_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign idex_valid     = valid_q;
    assign idex_op1       = op1_q;
    assign idex_op2       = op2_q;
    assign idex_dst       = dst_q;
    assign idex_rdata1    = rdata1_q;
    assign idex_rdata2    = rdata2_q;
    assign idex_imm       = imm_q;
    assign idex_reg_write = ctrl_q.reg_write;
    assign idex_mem_read  = ctrl_q.mem_read;
    assign idex_mem_write = ctrl_q.mem_write;
    assign idex_alu_op    = ctrl_q.alu_op;
    assign stall_count    = cnt_q;

endmodule
